// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Purpose  : Multi-ported register file with two asynchronous read ports and
//            two write ports. A hardware clear sequence initialises the array
//            after reset or on request. Register 0 is hardwired to zero, and
//            the stack-pointer slot is preloaded during clear.
// Ports    : clk, reset_n (async, active-low), clear_req
//            rs1/rs2 -> rs1_dout/rs2_dout   read ports (write-through bypass)
//            we0/rd0/rd0_din, we1/rd1/rd1_din   write ports (port 1 wins)
//            ready        high once the clear sequence has finished
//            wr_conflict  one-cycle pulse after a same-address dual write
// Revision : 1.0  initial release
// ============================================================================
module regfile_mp #(
    parameter int          XLEN    = 32,
    parameter int          NREG    = 32,
    parameter int          SP_IDX  = 2,
    parameter logic [31:0] SP_INIT = 32'h2ffc,
    localparam int         AW      = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clear_req,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rs1_dout,
    output logic [XLEN-1:0] rs2_dout,
    input  logic            we0,
    input  logic [AW-1:0]   rd0,
    input  logic [XLEN-1:0] rd0_din,
    input  logic            we1,
    input  logic [AW-1:0]   rd1,
    input  logic [XLEN-1:0] rd1_din,
    output logic            ready,
    output logic            wr_conflict
);

    localparam logic [AW-1:0]   c_SP_IDX   = AW'(SP_IDX);
    localparam logic [AW-1:0]   c_LAST_IDX = AW'(NREG - 1);
    localparam logic [XLEN-1:0] c_SP_INIT  = XLEN'(SP_INIT);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_idx_q, clr_idx_d;
    logic            wr_conflict_q, wr_conflict_d;

    // Storage has no reset; the clear sequence initialises it.
    logic [XLEN-1:0] rf [NREG];

    logic            wr0_en;
    logic            wr1_en;

    assign ready       = (state_q == ST_READY);
    assign wr_conflict = wr_conflict_q;

    // Writes to index 0 are dropped here so neither the array nor the
    // bypass/conflict logic ever sees them.
    assign wr0_en = ready && we0 && (rd0 != '0);
    assign wr1_en = ready && we1 && (rd1 != '0);

    always_comb begin
        state_d       = state_q;
        clr_idx_d     = clr_idx_q;
        wr_conflict_d = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                if (clear_req) begin
                    clr_idx_d = '0;
                end else if (clr_idx_q == c_LAST_IDX) begin
                    state_d   = ST_READY;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + AW'(1);
                end
            end
            ST_READY: begin
                if (clear_req) begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = '0;
                end else begin
                    // The pulse lands in the next cycle, which must be READY,
                    // hence the clear_req gating.
                    wr_conflict_d = wr0_en && wr1_en && (rd0 == rd1);
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_CLEAR;
            clr_idx_q     <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_idx_q     <= clr_idx_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    // Port 1 is assigned last so it wins a same-address dual write.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            rf[clr_idx_q] <= (clr_idx_q == c_SP_IDX) ? c_SP_INIT : '0;
        end else begin
            if (wr0_en) begin
                rf[rd0] <= rd0_din;
            end
            if (wr1_en) begin
                rf[rd1] <= rd1_din;
            end
        end
    end

    // Read ports: zero while clearing or for index 0, otherwise the bypass
    // value (port 1 first) ahead of the stored word.
    always_comb begin
        rs1_dout = '0;
        if (ready && (rs1 != '0)) begin
            if (wr1_en && (rd1 == rs1)) begin
                rs1_dout = rd1_din;
            end else if (wr0_en && (rd0 == rs1)) begin
                rs1_dout = rd0_din;
            end else begin
                rs1_dout = rf[rs1];
            end
        end
    end

    always_comb begin
        rs2_dout = '0;
        if (ready && (rs2 != '0)) begin
            if (wr1_en && (rd1 == rs2)) begin
                rs2_dout = rd1_din;
            end else if (wr0_en && (rd0 == rs2)) begin
                rs2_dout = rd0_din;
            end else begin
                rs2_dout = rf[rs2];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Purpose  : Self-checking bench for regfile_mp: default instance (32 x 32)
//            plus a 16 x 64 instance, randomized traffic against a
//            behavioural register-array model.
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        clear_req;
    logic [4:0]  rs1, rs2, rd0, rd1;
    logic [31:0] rs1_dout, rs2_dout, rd0_din, rd1_din;
    logic        we0, we1, ready, wr_conflict;

    logic        p_clear_req;
    logic [3:0]  p_rs1, p_rs2, p_rd0, p_rd1;
    logic [63:0] p_rs1_dout, p_rs2_dout, p_rd0_din, p_rd1_din;
    logic        p_we0, p_we1, p_ready, p_wr_conflict;

    int checks = 0;
    int errors = 0;

    logic [31:0] m32 [32];

    regfile_mp dut (
        .clk(clk), .reset_n(reset_n), .clear_req(clear_req),
        .rs1(rs1), .rs2(rs2), .rs1_dout(rs1_dout), .rs2_dout(rs2_dout),
        .we0(we0), .rd0(rd0), .rd0_din(rd0_din),
        .we1(we1), .rd1(rd1), .rd1_din(rd1_din),
        .ready(ready), .wr_conflict(wr_conflict)
    );

    regfile_mp #(.XLEN(64), .NREG(16)) dut16 (
        .clk(clk), .reset_n(reset_n), .clear_req(p_clear_req),
        .rs1(p_rs1), .rs2(p_rs2), .rs1_dout(p_rs1_dout), .rs2_dout(p_rs2_dout),
        .we0(p_we0), .rd0(p_rd0), .rd0_din(p_rd0_din),
        .we1(p_we1), .rd1(p_rd1), .rd1_din(p_rd1_din),
        .ready(p_ready), .wr_conflict(p_wr_conflict)
    );

    // ---------------- reference model ----------------
    task automatic model_clear;
        for (int i = 0; i < 32; i++) m32[i] = 32'h0;
        m32[2] = 32'h2ffc;
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] rs);
        if (rs == 5'd0)                 return 32'h0;
        if (we1 && rd1 == rs)           return rd1_din;
        if (we0 && rd0 == rs)           return rd0_din;
        return m32[rs];
    endfunction

    task automatic model_commit;
        if (we0 && rd0 != 5'd0) m32[rd0] = rd0_din;
        if (we1 && rd1 != 5'd0) m32[rd1] = rd1_din;
    endtask

    task automatic idle;
        we0 = 1'b0; we1 = 1'b0; clear_req = 1'b0;
        rd0 = 5'd0; rd1 = 5'd0; rd0_din = 32'h0; rd1_din = 32'h0;
    endtask

    task automatic tick_commit;
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic read_all(input string name);
        idle();
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i);
            rs2 = 5'(31 - i);
            #1;
            checks++;
            if (rs1_dout !== exp_read(rs1) || rs2_dout !== exp_read(rs2)) begin
                errors++;
                $display("FAIL %s idx %0d got %h/%h exp %h/%h", name, i,
                         rs1_dout, rs2_dout, exp_read(rs1), exp_read(rs2));
            end
        end
    endtask

    // Counts edges until ready rises, driving (ignored) random writes and
    // checking zero reads / no conflict while not ready.
    task automatic count_clear(output int n);
        n = 0;
        for (int e = 1; e <= 60 && n == 0; e++) begin
            @(posedge clk); #1;
            if (ready) begin
                n = e;
                idle();
            end else begin
                we0 = 1'($urandom); we1 = 1'($urandom);
                rd0 = 5'($urandom); rd1 = $urandom_range(0, 1) ? rd0 : 5'($urandom);
                rd0_din = $urandom; rd1_din = $urandom;
                rs1 = rd0; rs2 = 5'($urandom);
                #1;
                checks++;
                if (rs1_dout !== 32'h0 || rs2_dout !== 32'h0 || wr_conflict !== 1'b0) begin
                    errors++;
                    $display("FAIL clear_outputs got %h/%h/%b exp 0/0/0",
                             rs1_dout, rs2_dout, wr_conflict);
                end
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        int r32, r16;
        reset_n = 1'b0;
        idle();
        p_clear_req = 1'b0; p_we0 = 1'b0; p_we1 = 1'b0;
        p_rd0 = 4'd0; p_rd1 = 4'd0; p_rd0_din = 64'h0; p_rd1_din = 64'h0;
        p_rs1 = 4'd0; p_rs2 = 4'd0; rs1 = 5'd0; rs2 = 5'd0;
        repeat (2) @(posedge clk);
        #3;
        checks++;
        if (ready !== 1'b0 || wr_conflict !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got ready=%b conf=%b exp 0/0", ready, wr_conflict);
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL release_ready got %b exp 0", ready);
        end
        r32 = 0; r16 = 0;
        for (int e = 1; e <= 60 && (r32 == 0 || r16 == 0); e++) begin
            @(posedge clk); #1;
            if (ready   && r32 == 0) r32 = e;
            if (p_ready && r16 == 0) r16 = e;
            if (!ready) begin
                we0 = 1'($urandom); we1 = 1'($urandom);
                rd0 = 5'($urandom); rd1 = 5'($urandom);
                rd0_din = $urandom; rd1_din = $urandom;
                rs1 = rd0; rs2 = 5'($urandom);
                #1;
                checks++;
                if (rs1_dout !== 32'h0 || rs2_dout !== 32'h0) begin
                    errors++;
                    $display("FAIL clear_reads got %h/%h exp 0/0", rs1_dout, rs2_dout);
                end
            end else begin
                idle();
            end
        end
        checks++;
        if (r32 != 32) begin
            errors++;
            $display("FAIL clear_len32 got %0d exp 32", r32);
        end
        checks++;
        if (r16 != 16) begin
            errors++;
            $display("FAIL clear_len16 got %0d exp 16", r16);
        end
        model_clear();
        read_all("post_reset_read");
        rs1 = 5'd2; #1;
        checks++;
        if (rs1_dout !== 32'h2ffc) begin
            errors++;
            $display("FAIL sp_init got %h exp 00002ffc", rs1_dout);
        end
    endtask

    task automatic test_write_bypass;
        idle();
        we0 = 1'b1; rd0 = 5'd5; rd0_din = 32'hdeadbeef; rs1 = 5'd5; rs2 = 5'd0;
        #1;
        checks++;
        if (rs1_dout !== 32'hdeadbeef) begin
            errors++;
            $display("FAIL bypass_same got %h exp deadbeef", rs1_dout);
        end
        tick_commit();
        idle();
        #1;
        checks++;
        if (rs1_dout !== 32'hdeadbeef) begin
            errors++;
            $display("FAIL bypass_next got %h exp deadbeef", rs1_dout);
        end
    endtask

    task automatic test_reg0;
        idle();
        we0 = 1'b1; we1 = 1'b1; rd0 = 5'd0; rd1 = 5'd0;
        rd0_din = 32'h1234; rd1_din = 32'h1234; rs1 = 5'd0;
        #1;
        checks++;
        if (rs1_dout !== 32'h0) begin
            errors++;
            $display("FAIL reg0_same got %h exp 0", rs1_dout);
        end
        tick_commit();
        idle();
        #1;
        checks++;
        if (rs1_dout !== 32'h0 || wr_conflict !== 1'b0) begin
            errors++;
            $display("FAIL reg0_next got %h conf=%b exp 0/0", rs1_dout, wr_conflict);
        end
    endtask

    task automatic test_conflict;
        idle();
        we0 = 1'b1; we1 = 1'b1; rd0 = 5'd7; rd1 = 5'd7;
        rd0_din = 32'h11; rd1_din = 32'h22; rs1 = 5'd7; rs2 = 5'd7;
        #1;
        checks++;
        if (rs1_dout !== 32'h22 || rs2_dout !== 32'h22) begin
            errors++;
            $display("FAIL conflict_bypass got %h/%h exp 22/22", rs1_dout, rs2_dout);
        end
        tick_commit();
        idle();
        #1;
        checks++;
        if (wr_conflict !== 1'b1) begin
            errors++;
            $display("FAIL conflict_pulse got %b exp 1", wr_conflict);
        end
        checks++;
        if (rs1_dout !== 32'h22) begin
            errors++;
            $display("FAIL conflict_store got %h exp 22", rs1_dout);
        end
        @(posedge clk); #1;
        checks++;
        if (wr_conflict !== 1'b0) begin
            errors++;
            $display("FAIL conflict_one_cycle got %b exp 0", wr_conflict);
        end
    endtask

    task automatic test_random;
        logic exp_conf;
        idle();
        for (int n = 0; n < 400; n++) begin
            we0 = 1'($urandom); we1 = 1'($urandom);
            rd0 = 5'($urandom);
            rd1 = ($urandom_range(0, 3) == 0) ? rd0 : 5'($urandom);
            rd0_din = $urandom; rd1_din = $urandom;
            case ($urandom_range(0, 2))
                0:       rs1 = rd0;
                1:       rs1 = rd1;
                default: rs1 = 5'($urandom);
            endcase
            rs2 = ($urandom_range(0, 1) == 0) ? rd1 : 5'($urandom);
            #1;
            checks++;
            if (rs1_dout !== exp_read(rs1) || rs2_dout !== exp_read(rs2)) begin
                errors++;
                $display("FAIL rand_read n=%0d got %h/%h exp %h/%h", n,
                         rs1_dout, rs2_dout, exp_read(rs1), exp_read(rs2));
            end
            exp_conf = we0 && we1 && (rd0 == rd1) && (rd0 != 5'd0);
            tick_commit();
            checks++;
            if (wr_conflict !== exp_conf) begin
                errors++;
                $display("FAIL rand_conflict n=%0d got %b exp %b", n, wr_conflict, exp_conf);
            end
        end
        read_all("rand_final_read");
    endtask

    task automatic test_mid_clear;
        int n;
        idle();
        we0 = 1'b1; rd0 = 5'd3; rd0_din = 32'h5a5a0003;
        tick_commit();
        idle();
        rs1 = 5'd3; #1;
        checks++;
        if (rs1_dout !== 32'h5a5a0003) begin
            errors++;
            $display("FAIL pre_clear_store got %h exp 5a5a0003", rs1_dout);
        end
        clear_req = 1'b1; #1;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL req_cycle_ready got %b exp 1", ready);
        end
        @(posedge clk); #1;
        clear_req = 1'b0;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_entry got %b exp 0", ready);
        end
        for (int c = 0; c < 10; c++) begin
            we0 = 1'b1; rd0 = 5'd3; rd0_din = $urandom | 32'h1;
            rs1 = 5'd3; rs2 = 5'($urandom);
            #1;
            checks++;
            if (ready !== 1'b0 || rs1_dout !== 32'h0 || rs2_dout !== 32'h0) begin
                errors++;
                $display("FAIL mid_clear c=%0d got r=%b %h/%h exp 0 0/0", c,
                         ready, rs1_dout, rs2_dout);
            end
            @(posedge clk); #1;
        end
        we0 = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0 || wr_conflict !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got %b/%b exp 0/0", ready, wr_conflict);
        end
        #2 reset_n = 1'b1;
        count_clear(n);
        checks++;
        if (n != 32) begin
            errors++;
            $display("FAIL reclear_len got %0d exp 32", n);
        end
        model_clear();
        rs1 = 5'd3; #1;
        checks++;
        if (rs1_dout !== 32'h0) begin
            errors++;
            $display("FAIL rf3_cleared got %h exp 0", rs1_dout);
        end
        read_all("mid_clear_read");
    endtask

    task automatic test_clear_restart;
        int n;
        idle();
        we0 = 1'b1; rd0 = 5'd9; rd0_din = 32'hcafe0009;
        tick_commit();
        idle();
        clear_req = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        clear_req = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        count_clear(n);
        checks++;
        if (n != 32) begin
            errors++;
            $display("FAIL restart_len got %0d exp 32", n);
        end
        model_clear();
        read_all("restart_read");
    endtask

    task automatic test_params;
        logic [63:0] a, b, e;
        for (int w = 0; w < 40 && !p_ready; w++) @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            p_rs1 = 4'(i); #1;
            e = (i == 2) ? 64'h2ffc : 64'h0;
            checks++;
            if (p_rs1_dout !== e) begin
                errors++;
                $display("FAIL p_clear_read idx %0d got %h exp %h", i, p_rs1_dout, e);
            end
        end
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        p_we0 = 1'b1; p_rd0 = 4'd4; p_rd0_din = a;
        p_we1 = 1'b1; p_rd1 = 4'd9; p_rd1_din = b;
        @(posedge clk); #1;
        p_we0 = 1'b0; p_we1 = 1'b0;
        p_rs1 = 4'd4; p_rs2 = 4'd9; #1;
        checks++;
        if (p_rs1_dout !== a || p_rs2_dout !== b || p_wr_conflict !== 1'b0) begin
            errors++;
            $display("FAIL p_dual_write got %h/%h/%b exp %h/%h/0",
                     p_rs1_dout, p_rs2_dout, p_wr_conflict, a, b);
        end
    endtask

    initial begin
        test_reset();
        test_write_bypass();
        test_reg0();
        test_conflict();
        test_random();
        test_params();
        test_mid_clear();
        test_clear_restart();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREG, default 32, register count; power of 2, at least 4; AW = log2(NREG).
REQ-003 SHALL have parameter SP_IDX, default 2, index loaded with SP_INIT on clear.
REQ-004 SHALL have parameter SP_INIT, default 32'h2ffc, stack-pointer init value, truncated to XLEN.
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port clear_req, input, 1, synchronous request to re-run the clear sequence.
REQ-008 SHALL have ports rs1 and rs2, input, AW each, read addresses.
REQ-009 SHALL have ports rs1_dout and rs2_dout, output, XLEN each, read data.
REQ-010 SHALL have ports we0 (input, 1), rd0 (input, AW) and rd0_din (input, XLEN), write port 0.
REQ-011 SHALL have ports we1 (input, 1), rd1 (input, AW) and rd1_din (input, XLEN), write port 1.
REQ-012 SHALL have port ready, output, 1, high when the file accepts writes and returns stored data.
REQ-013 SHALL have port wr_conflict, output, 1, registered pulse flagging a same-address dual write.

Function
REQ-014 SHALL contain an FSM with states CLEAR and READY; ready = (state == READY), combinational from the state register.
REQ-015 In CLEAR, SHALL hold counter clr_idx (AW bits); each cycle write rf[clr_idx] = (clr_idx == SP_IDX) ? SP_INIT : 0, then increment clr_idx.
REQ-016 In CLEAR, after the cycle writing clr_idx = NREG-1, SHALL go to READY; total CLEAR duration is exactly NREG cycles.
REQ-017 In READY, clear_req = 1 SHALL go to CLEAR with clr_idx = 0 on the next edge; in CLEAR, clear_req = 1 SHALL restart clr_idx at 0.
REQ-018 In CLEAR, SHALL ignore we0 and we1 and drive both read outputs to 0.
REQ-019 In READY, reads SHALL be asynchronous: rsX_dout = rf[rsX], except as stated in REQ-020 to REQ-022.
REQ-020 Register 0 SHALL be hardwired to zero: reads of index 0 return 0, and writes to index 0 are discarded.
REQ-021 Write-through bypass: if weN = 1, rdN == rsX and rdN != 0 in READY, rsX_dout SHALL equal rdN_din in the same cycle.
REQ-022 If both write ports target the same nonzero rsX, the bypass SHALL return rd1_din.
REQ-023 In READY, each enabled write port SHALL update its register on the rising edge.
REQ-024 If we0 = we1 = 1 and rd0 == rd1 != 0, port 1 SHALL win and wr_conflict SHALL be 1 for exactly the following cycle.
REQ-025 Writes on distinct addresses SHALL both commit in the same cycle.
REQ-026 wr_conflict SHALL be 0 in all other cases, including dual writes to index 0 and any cycle in CLEAR.

Reset
REQ-027 reset_n = 0 SHALL immediately force state = CLEAR, clr_idx = 0, wr_conflict = 0 and ready = 0, independent of clk.
REQ-028 Array contents SHALL NOT be asynchronously reset; the CLEAR sequence initialises them after reset_n rises.
REQ-029 Asserting reset_n mid-CLEAR or mid-READY SHALL abort the current activity and restart CLEAR from index 0 on release.

Verification
REQ-030 Reset scenario: release reset_n, default params -> ready = 0 for exactly 32 cycles, then 1; reads of all registers give 0 except rf[2] = 32'h2ffc.
REQ-031 Write and bypass scenario: we0 = 1, rd0 = 5, rd0_din = 32'hdeadbeef, rs1 = 5 in the same cycle -> rs1_dout = 32'hdeadbeef that cycle and the next.
REQ-032 Register 0 scenario: we0 = we1 = 1, rd0 = rd1 = 0, data 32'h1234 -> rs1 = 0 reads 0 same and next cycle; wr_conflict stays 0.
REQ-033 Conflict scenario: we0 = we1 = 1, rd0 = rd1 = 7, data 32'h11 and 32'h22 -> rf[7] = 32'h22; wr_conflict = 1 for one cycle; same-cycle bypass returns 32'h22.
REQ-034 Mid-clear scenario: pulse clear_req in READY, write we0 to rd0 = 3 during CLEAR, pulse reset_n low at clear cycle 10 -> write ignored; reads = 0 while not ready; ready returns 32 cycles after reset_n release; rf[3] = 0.
REQ-035 Parameter scenario: NREG = 16, XLEN = 64 -> clear lasts 16 cycles; rf[2] = 64'h2ffc; dual writes to 4 and 9 both commit.
